// File: rtl/div_radix2.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// quotient goes to LO and remainder to HI, stall_div holds the pipeline meanwhile.
module div_radix2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             is_signed,
   input  logic             annul,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             stall_div,
   output logic             ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

   stateT            state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] partRem;
   logic [WIDTH-1:0] work;
   logic             qNeg;
   logic             rNeg;

   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             qBit;
   logic [WIDTH-1:0] nextRem;
   logic [WIDTH-1:0] nextWork;

   // work shifts dividend bits out of its MSB while quotient bits enter at its LSB
   always_comb begin
      absA     = (is_signed && opa[WIDTH-1]) ? -opa : opa;
      absB     = (is_signed && opb[WIDTH-1]) ? -opb : opb;
      shifted  = {partRem, work[WIDTH-1]};
      diff     = shifted - {1'b0, divisor};
      qBit     = ~diff[WIDTH];
      nextRem  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      nextWork = {work[WIDTH-2:0], qBit};
   end

   assign stall_div = ((state == IDLE) && start && !annul) || (state == BUSY);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         count     <= '0;
         divisor   <= '0;
         partRem   <= '0;
         work      <= '0;
         qNeg      <= 1'b0;
         rNeg      <= 1'b0;
         ready     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
               if (start && !annul) begin
                  if (opb == '0) begin
                     quotient  <= '1;
                     remainder <= opa;
                     ready     <= 1'b1;
                     state     <= DONE;
                  end else begin
                     divisor <= absB;
                     work    <= absA;
                     partRem <= '0;
                     count   <= '0;
                     qNeg    <= is_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                     rNeg    <= is_signed && opa[WIDTH-1];
                     state   <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (annul) begin
                  state <= IDLE;
               end else begin
                  partRem <= nextRem;
                  work    <= nextWork;
                  count   <= count + CW'(1);
                  // The final iteration commits the sign-corrected result directly
                  if (count == CW'(WIDTH - 1)) begin
                     quotient  <= qNeg ? -nextWork : nextWork;
                     remainder <= rNeg ? -nextRem : nextRem;
                     ready     <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               ready <= 1'b0;
               state <= IDLE;
            end
            default: begin
               ready <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
